ifra_slv: RTL and testbench

IFRA_SLV -- requirements
Module: ifra_slv

---
 rtl/ifra_slv.sv | 88 ++++++++
 tb/tb_ifra_slv.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ifra_slv.sv
// rtl/ifra_slv.sv - req/ack slave that captures one word per handshake into a FWFT receive FIFO
// Optional capture counter output rx_count is enabled by defining IFRA_SLV_CNT_EN.
module ifra_slv #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic                       ack,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     level
`ifdef IFRA_SLV_CNT_EN
    ,
    output logic [15:0]                rx_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACKED = 1'b1;

    logic [0:0]            state;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  capture;
    logic                  pop;

    // Full check uses the registered level, so a same-edge pop never frees room for a capture.
    assign capture   = (state == IDLE) && req && (level_q < FULL);
    assign pop       = (level_q != '0) && out_ready;
    assign ack       = state;
    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign level     = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (capture) state <= ACKED;
                ACKED:   if (!req)    state <= IDLE;
                default:              state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({capture, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is not reset; out_data is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= din;
    end

`ifdef IFRA_SLV_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count <= '0;
        end else if (capture && (rx_count != 16'hFFFF)) begin
            rx_count <= rx_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifra_slv.sv
// tb/tb_ifra_slv.sv - self-checking bench for ifra_slv against a queue-based reference model
module tb_ifra_slv;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [DW-1:0] din;
    logic          ack;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [$clog2(DEPTH):0] level;
`ifdef IFRA_SLV_CNT_EN
    logic [15:0]   rx_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] q[$];
    bit            m_ack;
    int            m_cnt;

    always #5 clk = ~clk;

    ifra_slv #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
`ifdef IFRA_SLV_CNT_EN
        ,
        .rx_count  (rx_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ack"}, 32'(ack), 32'(m_ack));
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".out_data"}, 32'(out_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
`ifdef IFRA_SLV_CNT_EN
        chk({tag, ".rx_count"}, 32'(rx_count), 32'(m_cnt));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then compare.
    task automatic step(input string tag, input logic r, input logic [DW-1:0] d, input logic rdy);
        bit cap;
        bit pp;
        req       = r;
        din       = d;
        out_ready = rdy;
        @(posedge clk);
        cap = !m_ack && r && (q.size() < DEPTH);
        pp  = (q.size() > 0) && rdy;
        if (pp)  void'(q.pop_front());
        if (cap) begin
            q.push_back(d);
            if (m_cnt < 65535) m_cnt++;
        end
        m_ack = m_ack ? bit'(r) : cap;
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        q.delete();
        m_ack = 1'b0;
        m_cnt = 0;
        check_model(tag);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        m_ack     = 1'b0;
        m_cnt     = 0;
        #12;
        check_model("reset");
        rst_n = 1'b1;

        // Single beat, req held three cycles
        step("single1", 1'b1, 8'hA5, 1'b0);
        chk("single_ack_rise", 32'(ack), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5);
        step("single2", 1'b1, 8'h00, 1'b0);
        step("single3", 1'b1, 8'hFF, 1'b0);
        chk("single_one_write", 32'(level), 32'd1);
        step("single_fall", 1'b0, 8'h00, 1'b0);
        chk("single_ack_fall", 32'(ack), 32'd0);
        for (int i = 0; i < 1; i++) step("single_drain", 1'b0, 8'h00, 1'b1);

        // Fill to full, then backpressure on the fifth write
        for (int i = 1; i <= 4; i++) begin
            step("fill_req", 1'b1, DW'(i), 1'b0);
            step("fill_rel", 1'b0, 8'h00, 1'b0);
        end
        chk("fill_level", 32'(level), 32'd4);
        step("fill_bp", 1'b1, 8'h05, 1'b0);
        chk("fill_bp_ack", 32'(ack), 32'd0);
        step("full_pop", 1'b1, 8'h05, 1'b1);
        chk("full_pop_no_cap", 32'(ack), 32'd0);
        chk("full_pop_level", 32'(level), 32'd3);
        step("full_cap", 1'b1, 8'h05, 1'b0);
        chk("full_cap_ack", 32'(ack), 32'd1);
        step("full_rel", 1'b0, 8'h00, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            chk("fill_order", 32'(out_data), 32'(i));
            step("fill_drain", 1'b0, 8'h00, 1'b1);
        end

        // Streaming with the consumer always ready
        for (int i = 0; i < 8; i++) begin
            step("stream_req", 1'b1, DW'(8'h10 + i), 1'b1);
            chk("stream_head", 32'(out_data), 32'(8'h10 + i));
            step("stream_rel", 1'b0, 8'h00, 1'b1);
            chk("stream_level_max", 32'(level <= 1), 32'd1);
        end

        // Reset with two entries buffered and ack high
        step("mr_w1", 1'b1, 8'h31, 1'b0);
        step("mr_r1", 1'b0, 8'h00, 1'b0);
        step("mr_w2", 1'b1, 8'h32, 1'b0);
        chk("mr_pre_level", 32'(level), 32'd2);
        chk("mr_pre_ack", 32'(ack), 32'd1);
        req = 1'b1;
        #2;
        do_reset("mid_reset");
        step("mr_recap", 1'b1, 8'h77, 1'b0);
        chk("mr_recap_level", 32'(level), 32'd1);
        step("mr_rel", 1'b0, 8'h00, 1'b1);
`ifdef IFRA_SLV_CNT_EN
        do_reset("cnt_reset");
        for (int i = 0; i < 3; i++) begin
            step("cnt_req", 1'b1, DW'(i), 1'b1);
            step("cnt_rel", 1'b0, 8'h00, 1'b1);
        end
        chk("cnt_three", 32'(rx_count), 32'd3);
        do_reset("cnt_clear");
        chk("cnt_cleared", 32'(rx_count), 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("random", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 6; i++) step("final_drain", 1'b0, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
